rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8_pkg.sv | 6 +
 rtl/rr_arbiter8_decode.sv | 11 +
 rtl/rr_arbiter8.sv | 90 +++++++++
 tb/tb_rr_arbiter8.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared FSM state encoding and sizing constants for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;
    localparam int NREQ = 8;
    localparam int IDXW = 3;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
endpackage

// File: rtl/rr_arbiter8_decode.sv
// Decode3to8: binary-to-one-hot decoder.
//   idx_i    - binary index
//   onehot_o - one-hot decode of idx_i
module Decode3to8
    import rr_arbiter8_pkg::*;
(
    input  logic [IDXW-1:0] idx_i,
    output logic [NREQ-1:0] onehot_o
);
    assign onehot_o = NREQ'(1) << idx_i;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with a per-grant hold limit.
//   Clk      - clock, rising edge
//   Rst_n    - asynchronous active-low reset
//   Req      - per-requester request lines
//   Done     - owner releases the resource
//   Gnt      - one-hot grant (zero when idle)
//   GntIdx   - binary owner index, valid while GntValid
//   GntValid - resource currently granted
//   Timeout  - one-cycle pulse when a grant is revoked by hold expiry
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [NREQ-1:0] Req,
    input  logic            Done,
    output logic [NREQ-1:0] Gnt,
    output logic [IDXW-1:0] GntIdx,
    output logic            GntValid,
    output logic            Timeout
);
    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d, idx_q, idx_d, off, win;
    logic [7:0]      hold_q, hold_d;
    logic            valid_q, valid_d, timeout_q, timeout_d;
    logic [NREQ-1:0] gnt_q, gnt_d, dec;
    logic [2*NREQ-1:0] rot2;
    logic            rel_norm, expire;
    // Rotate requests so bit 0 is the pointer's requester; lowest set bit wins.
    always_comb begin
        rot2 = {Req, Req} >> ptr_q;
        off  = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot2[k]) off = IDXW'(k);
        win = ptr_q + off;
    end
    assign rel_norm = Done || !Req[idx_q];
    assign expire   = hold_q == 8'(MAX_HOLD - 1);
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            hold_d  = '0;
            state_d = |Req ? GRANT : IDLE;
            valid_d = |Req;
            idx_d   = |Req ? win : '0;
        end else if (rel_norm || expire) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            idx_d     = '0;
            hold_d    = '0;
            ptr_d     = idx_q + IDXW'(1);
            // A normal release coinciding with expiry takes precedence: no pulse.
            timeout_d = !rel_norm;
        end else begin
            hold_d = hold_q + 8'd1;
        end
    end
    Decode3to8 u_dec (.idx_i(idx_d), .onehot_o(dec));
    assign gnt_d = valid_d ? dec : '0;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            gnt_q     <= gnt_d;
        end
    end
    assign Gnt      = gnt_q;
    assign GntIdx   = idx_q;
    assign GntValid = valid_q;
    assign Timeout  = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: randomized and directed checks of rr_arbiter8 (MAX_HOLD=16 and MAX_HOLD=1) against a behavioural model.
module tb_rr_arbiter8;
    logic       Clk = 1'b0;
    logic       Rst_n = 1'b1;
    logic [7:0] Req = '0;
    logic       Done = 1'b0;
    logic [7:0] gnt [2];
    logic [2:0] idx [2];
    logic       valid [2];
    logic       tmo [2];
    int n_tests = 0;
    int n_fail = 0;
    int m_own [2];
    int m_ptr [2];
    int m_held [2];
    int m_max [2] = '{16, 1};
    logic m_to [2];
    logic [7:0] r_cur;

    rr_arbiter8 #(.MAX_HOLD(16)) u0 (.Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Done(Done),
        .Gnt(gnt[0]), .GntIdx(idx[0]), .GntValid(valid[0]), .Timeout(tmo[0]));
    rr_arbiter8 #(.MAX_HOLD(1)) u1 (.Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Done(Done),
        .Gnt(gnt[1]), .GntIdx(idx[1]), .GntValid(valid[1]), .Timeout(tmo[1]));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: an owner is granted for at most m_max cycles; release also on Done or owner dropping Req.
    task automatic model_step(input int i, input logic [7:0] r, input logic d);
        m_to[i] = 1'b0;
        if (m_own[i] < 0) begin
            for (int k = 0; k < 8; k++)
                if (m_own[i] < 0 && r[(m_ptr[i] + k) % 8]) begin
                    m_own[i]  = (m_ptr[i] + k) % 8;
                    m_held[i] = 1;
                end
        end else if (d || !r[m_own[i]] || m_held[i] == m_max[i]) begin
            m_to[i]  = !(d || !r[m_own[i]]);
            m_ptr[i] = (m_own[i] + 1) % 8;
            m_own[i] = -1;
        end else begin
            m_held[i]++;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("gnt%0d", i), 32'(gnt[i]), m_own[i] < 0 ? 32'h0 : 32'(1) << m_own[i]);
            chk($sformatf("idx%0d", i), 32'(idx[i]), m_own[i] < 0 ? 32'h0 : 32'(m_own[i]));
            chk($sformatf("valid%0d", i), 32'(valid[i]), 32'(m_own[i] >= 0));
            chk($sformatf("timeout%0d", i), 32'(tmo[i]), 32'(m_to[i]));
        end
    endtask

    task automatic cycle(input logic [7:0] r, input logic d);
        @(negedge Clk);
        Req = r;
        Done = d;
        for (int i = 0; i < 2; i++) model_step(i, r, d);
        @(posedge Clk);
        #1;
        check_all();
    endtask

    // Asserts reset away from any clock edge and checks the outputs clear immediately.
    task automatic do_reset();
        @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        Req = '0;
        Done = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1;
            m_ptr[i] = 0;
            m_held[i] = 0;
            m_to[i] = 1'b0;
        end
        check_all();
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // Two requesters, Done three cycles after grant.
        cycle(8'h05, 1'b0);
        chk("r030_first", 32'(gnt[0]), 32'h01);
        cycle(8'h05, 1'b0);
        cycle(8'h05, 1'b1);
        chk("r030_idle", 32'(valid[0]), 32'h0);
        cycle(8'h05, 1'b0);
        chk("r030_second", 32'(gnt[0]), 32'h04);
        // All requesting, Done every grant: full rotation with wrap.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            cycle(8'hFF, 1'b0);
            chk("r031_idx", 32'(idx[0]), 32'(k % 8));
            cycle(8'hFF, 1'b1);
            chk("r031_gap", 32'(valid[0]), 32'h0);
        end
        // Hold expiry on requester 7.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            cycle(8'h80, 1'b0);
            chk("r032_hold", 32'(gnt[0]), 32'h80);
        end
        cycle(8'h80, 1'b0);
        chk("r032_tmo", 32'({gnt[0], tmo[0]}), 32'h001);
        cycle(8'h80, 1'b0);
        chk("r032_regrant", 32'({gnt[0], tmo[0]}), 32'h100);
        // Done on the last allowed cycle: normal release.
        for (int k = 0; k < 15; k++) cycle(8'h80, 1'b0);
        cycle(8'h80, 1'b1);
        chk("r033_notmo", 32'({gnt[0], tmo[0]}), 32'h000);
        // Owner drops request mid-grant.
        do_reset();
        cycle(8'h08, 1'b0);
        cycle(8'h08, 1'b0);
        cycle(8'h00, 1'b0);
        chk("r034_drop", 32'({gnt[0], tmo[0]}), 32'h000);
        cycle(8'h18, 1'b0);
        chk("r034_ptr", 32'(idx[0]), 32'd4);
        // Reset mid-grant, then arbitration restarts from pointer 0.
        do_reset();
        cycle(8'h08, 1'b0);
        cycle(8'h08, 1'b1);
        cycle(8'h20, 1'b0);
        chk("r035_own5", 32'(idx[0]), 32'd5);
        do_reset();
        cycle(8'h21, 1'b0);
        chk("r035_restart", 32'(idx[0]), 32'd0);
        // Randomized traffic with occasional resets.
        r_cur = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) r_cur = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(400) == 0) do_reset();
            cycle(r_cur, $urandom_range(19) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
